// File: rtl/vend_change_engine.sv
// -----------------------------------------------------------------------------
// vend_change_engine
//
// Credit / vend / change controller for the vending datapath. Accumulates
// quarter and dollar credit up to MAX_CREDIT, vends one of NUM_ITEMS items
// against the packed PRICE_LIST, then returns change through a ready/ack coin
// dispenser handshake, largest coin first. All money is counted in quarters.
//
// Optional feature macro: VEND_COIN_RETURN_EN
//   defined   -> a coin_return pulse in CREDIT refunds the full credit
//   undefined -> coin_return is ignored; credit only leaves through a vend
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous reset, active-low
//   quarter_in   in   one-cycle pulse, quarter inserted
//   dollar_in    in   one-cycle pulse, dollar inserted
//   selection    in   level; 0 = none, k selects item k-1
//   coin_return  in   cancel pulse (only with VEND_COIN_RETURN_EN)
//   coin_ack     in   dispenser took the presented coin
//   credit       out  current credit in quarters
//   coin_reject  out  one-cycle pulse, inserted coin bounced
//   vend         out  one-cycle pulse releasing an item
//   vend_item    out  0-based item index, valid while vend = 1
//   quarter_out  out  quarter presented to the dispenser
//   dollar_out   out  dollar presented to the dispenser
//   busy         out  high in VEND and CHANGE
// -----------------------------------------------------------------------------
module vend_change_engine #(
  parameter int                            CREDIT_W   = 5,
  parameter int                            MAX_CREDIT = 8,
  parameter int                            NUM_ITEMS  = 2,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICE_LIST = {5'd6, 5'd4},
  parameter int                            SEL_W      = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                quarter_in,
  input  logic                dollar_in,
  input  logic [SEL_W-1:0]    selection,
  input  logic                coin_return,
  input  logic                coin_ack,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_reject,
  output logic                vend,
  output logic [SEL_W-1:0]    vend_item,
  output logic                quarter_out,
  output logic                dollar_out,
  output logic                busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CREDIT = 2'd1,
    S_VEND   = 2'd2,
    S_CHANGE = 2'd3
  } state_e;

  // Acceptance arithmetic is one bit wider than the credit register so that
  // credit + coin can never wrap before it is compared with the limit.
  localparam logic [CREDIT_W:0]   QUARTER_W = (CREDIT_W+1)'(1);
  localparam logic [CREDIT_W:0]   DOLLAR_W  = (CREDIT_W+1)'(4);
  localparam logic [CREDIT_W:0]   MAX_W     = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] QUARTER_C = CREDIT_W'(1);
  localparam logic [CREDIT_W-1:0] DOLLAR_C  = CREDIT_W'(4);
  localparam logic [SEL_W-1:0]    MAX_SEL   = SEL_W'(NUM_ITEMS);
  localparam logic [SEL_W-1:0]    SEL_ONE   = SEL_W'(1);

  state_e              state_q,  state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [SEL_W-1:0]    item_q,   item_d;
  logic                reject_q, reject_d;

  // Price of a 0-based item index; out-of-range indices price at zero but are
  // never reached because selection is range-checked before latching.
  function automatic logic [CREDIT_W-1:0] item_price(input logic [SEL_W-1:0] idx);
    item_price = '0;
    for (int k = 0; k < NUM_ITEMS; k++) begin
      if (idx == SEL_W'(k)) item_price = PRICE_LIST[k*CREDIT_W +: CREDIT_W];
    end
  endfunction

  logic                sel_valid;
  logic [SEL_W-1:0]    sel_idx;
  logic [CREDIT_W-1:0] sel_price;
  logic [CREDIT_W:0]   sum;
  logic                accepted;
  logic                coin_pulse;

`ifndef VEND_COIN_RETURN_EN
  // Port kept for a uniform interface; intentionally unused in this build.
  logic unused_coin_return;
  assign unused_coin_return = coin_return;
`endif

  assign coin_pulse = quarter_in | dollar_in;
  assign sel_valid  = (selection != '0) && (selection <= MAX_SEL);
  assign sel_idx    = selection - SEL_ONE;
  assign sel_price  = item_price(sel_idx);

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    item_d   = item_q;
    reject_d = 1'b0;
    sum      = {1'b0, credit_q};
    accepted = 1'b0;

    unique case (state_q)
      S_IDLE, S_CREDIT: begin
        if (coin_pulse) begin
          // Dollar is evaluated first; a simultaneous quarter always bounces.
          if (dollar_in) begin
            if (sum + DOLLAR_W <= MAX_W) begin
              sum      = sum + DOLLAR_W;
              accepted = 1'b1;
            end else begin
              reject_d = 1'b1;
            end
          end
          if (quarter_in) begin
            if (!dollar_in && (sum + QUARTER_W <= MAX_W)) begin
              sum      = sum + QUARTER_W;
              accepted = 1'b1;
            end else begin
              reject_d = 1'b1;
            end
          end
          credit_d = sum[CREDIT_W-1:0];
          if (accepted) state_d = S_CREDIT;
        end else if (state_q == S_CREDIT) begin
`ifdef VEND_COIN_RETURN_EN
          if (coin_return) begin
            state_d = S_CHANGE;
          end else
`endif
          if (sel_valid && (credit_q >= sel_price)) begin
            state_d = S_VEND;
            item_d  = sel_idx;
          end
        end
      end

      S_VEND: begin
        reject_d = coin_pulse;
        credit_d = credit_q - item_price(item_q);
        state_d  = (credit_d != '0) ? S_CHANGE : S_IDLE;
      end

      S_CHANGE: begin
        reject_d = coin_pulse;
        if (coin_ack) begin
          credit_d = credit_q - ((credit_q >= DOLLAR_C) ? DOLLAR_C : QUARTER_C);
          if (credit_d == '0) state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      credit_q <= '0;
      item_q   <= '0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      item_q   <= item_d;
      reject_q <= reject_d;
    end
  end

  // Outputs decode registered state only; no input reaches an output
  // combinationally.
  assign credit      = credit_q;
  assign coin_reject = reject_q;
  assign vend        = (state_q == S_VEND);
  assign vend_item   = (state_q == S_VEND) ? item_q : '0;
  assign dollar_out  = (state_q == S_CHANGE) && (credit_q >= DOLLAR_C);
  assign quarter_out = (state_q == S_CHANGE) && (credit_q <  DOLLAR_C);
  assign busy        = (state_q == S_VEND) || (state_q == S_CHANGE);

endmodule

// File: doc/vend_change_engine.md
# vend_change_engine

Parametrised credit/vend/change controller for the vending datapath, replacing the fixed two-item, $2.00-limit change calculator. It accumulates quarter and dollar credit up to a configurable limit, vends any of `NUM_ITEMS` items against a packed price list, and returns change through a ready/ack coin-dispenser handshake, largest coin first. It sits between the coin acceptor and selection panel front end and the coin hopper and vend motor drivers.

## Interface

All money is counted in quarters (1 dollar = 4 quarters).

**Parameters**
- `CREDIT_W`, default 5: width of the credit and change registers.
- `MAX_CREDIT`, default 8: maximum credit held, in quarters ($2.00). Must be at most 2^CREDIT_W − 1.
- `NUM_ITEMS`, default 2: number of selectable items.
- `PRICE_LIST`, default {5'd6, 5'd4}: packed prices, `NUM_ITEMS`×`CREDIT_W` bits. Item k uses bits [k*CREDIT_W +: CREDIT_W]. Defaults are item0 = $1.00 and item1 = $1.50.
- `SEL_W`, default 2: selection width. Must be at least clog2(NUM_ITEMS+1).

**Ports**
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous reset, active-low.
- `quarter_in` input 1: one-cycle pulse when a quarter is inserted.
- `dollar_in` input 1: one-cycle pulse when a dollar is inserted.
- `selection` input SEL_W: level. 0 = none; value k selects item k−1. Values above NUM_ITEMS are invalid.
- `coin_return` input 1: cancel pulse (see Configuration).
- `coin_ack` input 1: dispenser has taken the coin currently presented.
- `credit` output CREDIT_W: current credit in quarters.
- `coin_reject` output 1: one-cycle pulse when an inserted coin is bounced.
- `vend` output 1: one-cycle pulse that releases an item.
- `vend_item` output SEL_W: item index (0-based), valid while `vend` = 1.
- `quarter_out` output 1: a quarter is presented to the dispenser.
- `dollar_out` output 1: a dollar is presented to the dispenser.
- `busy` output 1: high in VEND and CHANGE.

## Operation

**States**
- IDLE: credit = 0.
- CREDIT: credit > 0, accepting coins and selections.
- VEND: one cycle, vend pulse.
- CHANGE: returning coins.

**Coin acceptance (IDLE and CREDIT)**
- A coin is added if credit + value ≤ MAX_CREDIT. Otherwise `coin_reject` pulses and credit is unchanged.
- If `quarter_in` and `dollar_in` arrive in the same cycle, the dollar is evaluated first. The quarter is always rejected.
- Any accepted coin moves the FSM to CREDIT.

**Selection (CREDIT only)**
- Evaluated only in cycles with no coin pulse; a coin pulse has priority.
- Valid selection with credit ≥ price: go to VEND and latch the item index.
- Insufficient credit, or an invalid or zero selection: no action; stay in CREDIT.

**VEND**
- `vend` = 1 and `vend_item` = latched index.
- On exit, credit ← credit − price.
- Go to CHANGE if the remainder is > 0, else go to IDLE.
- Coins inserted during VEND or CHANGE are rejected with `coin_reject`.

**CHANGE**
- `dollar_out` = 1 while credit ≥ 4; otherwise `quarter_out` = 1. Never both at once.
- Each edge with `coin_ack` = 1 subtracts the presented coin's value (4 or 1).
- The output holds until acked. With `coin_ack` held high, coins are dispensed one per cycle.
- When credit reaches 0, go to IDLE.

**Arithmetic**
- Credit is unsigned CREDIT_W bits. The acceptance check is done at CREDIT_W+1 bits so it never wraps.

## Timing

- Reset (asserted asynchronously) forces: state = IDLE, credit = 0, and all outputs 0 (`vend`, `vend_item`, `quarter_out`, `dollar_out`, `coin_reject`, `busy`). Any in-flight change is discarded.
- A coin pulse sampled at edge t updates `credit` after edge t. `coin_reject` is high for the cycle after t.
- A selection sampled at edge t gives `vend` = 1 in cycle t+1. Reduced credit is visible after edge t+1, and the first change coin is presented in cycle t+2.
- `coin_ack` is ignored whenever neither `quarter_out` nor `dollar_out` is high.
- All outputs are registered or decoded from registered state only. There is no input-to-output combinational path.

## Configuration

- Macro `VEND_COIN_RETURN_EN`.
- Defined: a `coin_return` pulse in CREDIT (checked after coins, before selection) moves the FSM to CHANGE. The full credit is refunded through the normal coin handshake. `coin_return` is ignored in IDLE, VEND and CHANGE.
- Undefined: `coin_return` is ignored entirely. Credit can only leave through a vend.

## Test plan

All scenarios use the default parameters.

1. 4 × `quarter_in`, then `selection` = 1 → `vend` = 1 with `vend_item` = 0, credit goes 4 → 0, no change coins, return to IDLE.
2. `dollar_in` ×2 (credit 8), then `selection` = 2, `coin_ack` held high → `vend_item` = 1, then `quarter_out` for exactly 2 cycles, credit goes 2 → 1 → 0.
3. Credit 7, then `dollar_in` → `coin_reject` pulse and credit stays 7. Same-cycle `quarter_in` + `dollar_in` from credit 0 → credit = 4 and `coin_reject` = 1.
4. Credit 5 with `selection` = 2 held → no vend. Add a quarter → `vend` occurs in the cycle after the first coin-free edge.
5. Credit 6, select item 0, `coin_ack` held low for 3 cycles → `quarter_out` stays high. Assert `reset` mid-CHANGE → all outputs 0 immediately, credit = 0.
6. With `VEND_COIN_RETURN_EN`: credit 6, then `coin_return` → `dollar_out` then `quarter_out` ×2 (with acks), ending in IDLE. Without the macro: credit stays 6.
